// File: rtl/flopenr_skid.sv
// Two-entry valid/ready register slice built from enable-gated main and skid flops.
// in_ready depends only on state and flush, so no combinational path runs from out_ready back upstream.
module flopenr_skid #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       count
);

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b10
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] main_d;
    logic             main_en;
    logic             skid_en;
    logic             main_from_skid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_q <= '0;
        end else if (main_en) begin
            main_q <= main_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            skid_q <= '0;
        end else if (skid_en) begin
            skid_q <= in_data;
        end
    end

    assign main_d = main_from_skid ? skid_q : in_data;

    // Flush only rewinds the state; both data registers keep their contents.
    always_comb begin
        state_next     = state;
        main_en        = 1'b0;
        skid_en        = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (in_valid) begin
                        main_en    = 1'b1;
                        state_next = BUSY;
                    end
                end
                BUSY: begin
                    if (in_valid && out_ready) begin
                        main_en = 1'b1;
                    end else if (in_valid) begin
                        skid_en    = 1'b1;
                        state_next = FULL;
                    end else if (out_ready) begin
                        state_next = EMPTY;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        main_en        = 1'b1;
                        main_from_skid = 1'b1;
                        state_next     = BUSY;
                    end
                end
                default: begin
                    state_next = EMPTY;
                end
            endcase
        end
    end

    always_comb begin
        count = 2'd0;
        unique case (state)
            EMPTY:   count = 2'd0;
            BUSY:    count = 2'd1;
            FULL:    count = 2'd2;
            default: count = 2'd0;
        endcase
    end

    assign in_ready  = (state != FULL) && !flush;
    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;

endmodule

// File: tb/tb_flopenr_skid.sv
// Directed and scoreboard-checked bench for the flopenr_skid register slice.
// Inputs change 1 time unit after a rising edge; outputs are checked in the same quiet window.
module tb_flopenr_skid;

    logic       clk;
    logic       reset;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [1:0] count;

    int errors = 0;
    int checks = 0;

    logic [7:0] sb_q[$];
    logic       in_fire;
    logic       out_fire;

    flopenr_skid #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic check_output(input string tag, input logic exp_valid, input logic [7:0] exp_data,
                                input logic [1:0] exp_count, input logic exp_ready);
        check_val({tag, ".out_valid"}, {7'b0, out_valid}, {7'b0, exp_valid});
        check_val({tag, ".out_data"}, out_data, exp_data);
        check_val({tag, ".count"}, {6'b0, count}, {6'b0, exp_count});
        check_val({tag, ".in_ready"}, {7'b0, in_ready}, {7'b0, exp_ready});
    endtask

    task automatic apply_stimulus(input logic iv, input logic [7:0] id, input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        $display("[TB] start");
        reset = 1'b1;
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
        #2 reset = 1'b0;
        #1 check_output("reset_async", 1'b0, 8'h00, 2'd0, 1'b1);
        tick();
        tick();
        check_output("reset_held", 1'b0, 8'h00, 2'd0, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        tick();
        check_output("idle_after_reset", 1'b0, 8'h00, 2'd0, 1'b1);

        // Streaming with downstream always ready: one word per cycle, depth stays at one.
        apply_stimulus(1'b1, 8'h11, 1'b1, 1'b0);
        tick();
        check_output("stream_11", 1'b1, 8'h11, 2'd1, 1'b1);
        apply_stimulus(1'b1, 8'h22, 1'b1, 1'b0);
        tick();
        check_output("stream_22", 1'b1, 8'h22, 2'd1, 1'b1);
        apply_stimulus(1'b1, 8'h33, 1'b1, 1'b0);
        tick();
        check_output("stream_33", 1'b1, 8'h33, 2'd1, 1'b1);
        apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        check_output("stream_drain", 1'b0, 8'h33, 2'd0, 1'b1);

        // Stall fills the skid register; a word offered while full must be refused.
        apply_stimulus(1'b1, 8'hAA, 1'b0, 1'b0);
        tick();
        check_output("stall_aa", 1'b1, 8'hAA, 2'd1, 1'b1);
        apply_stimulus(1'b1, 8'h55, 1'b0, 1'b0);
        tick();
        check_output("stall_full", 1'b1, 8'hAA, 2'd2, 1'b0);
        apply_stimulus(1'b1, 8'hF0, 1'b0, 1'b0);
        tick();
        check_output("full_refuse_f0", 1'b1, 8'hAA, 2'd2, 1'b0);
        apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        check_output("unload_55", 1'b1, 8'h55, 2'd1, 1'b1);
        tick();
        check_output("unload_empty", 1'b0, 8'h55, 2'd0, 1'b1);

        // Flush from FULL with a competing push and pop.
        apply_stimulus(1'b1, 8'hAA, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b1, 8'h55, 1'b0, 1'b0);
        tick();
        check_output("refill_full", 1'b1, 8'hAA, 2'd2, 1'b0);
        apply_stimulus(1'b1, 8'h33, 1'b1, 1'b1);
        #1 check_val("flush_in_ready", {7'b0, in_ready}, 8'h00);
        tick();
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
        #1 check_output("after_flush", 1'b0, 8'hAA, 2'd0, 1'b1);
        tick();
        check_output("after_flush_idle", 1'b0, 8'hAA, 2'd0, 1'b1);

        // Asynchronous reset between edges while BUSY.
        apply_stimulus(1'b1, 8'hC3, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
        check_output("busy_c3", 1'b1, 8'hC3, 2'd1, 1'b1);
        @(negedge clk);
        #1 reset = 1'b0;
        #1 check_output("midcycle_reset", 1'b0, 8'h00, 2'd0, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        tick();
        check_output("post_reset_idle", 1'b0, 8'h00, 2'd0, 1'b1);

        // Random traffic against a FIFO scoreboard.
        sb_q.delete();
        for (int cyc = 0; cyc < 1000; cyc++) begin
            apply_stimulus(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                           1'($urandom_range(0, 1)), 1'b0);
            #1;
            check_val("rand.count", {6'b0, count}, 8'(sb_q.size()));
            check_val("rand.out_valid", {7'b0, out_valid}, {7'b0, (sb_q.size() != 0)});
            check_val("rand.in_ready", {7'b0, in_ready}, {7'b0, (sb_q.size() < 2)});
            if (sb_q.size() != 0) begin
                check_val("rand.out_data", out_data, sb_q[0]);
            end
            in_fire  = in_valid && (sb_q.size() < 2);
            out_fire = out_ready && (sb_q.size() != 0);
            @(posedge clk);
            if (out_fire) begin
                void'(sb_q.pop_front());
            end
            if (in_fire) begin
                sb_q.push_back(in_data);
            end
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/flopenr_skid.md
Name: flopenr_skid

Overview:
- Two-entry valid/ready register slice for the consumer side of an enable-loaded register path.
- Upstream pushes words with in_valid/in_ready. Downstream reads them with out_valid/out_ready.
- Built from enable-gated flops (main and skid registers).
- Breaks the combinational ready path between stages. Full throughput is kept: one word per cycle when downstream is always ready.

Parameters:
- WIDTH, 8, data word width in bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (reset=0 clears state immediately).
- flush  input  1  synchronous discard of all held words.
- in_valid  input  1  upstream word present on in_data.
- in_data  input  WIDTH  upstream word.
- in_ready  output  1  slice can accept a word this cycle.
- out_valid  output  1  out_data holds a valid word.
- out_data  output  WIDTH  oldest held word (main register).
- out_ready  input  1  downstream consumes out_data this cycle.
- count  output  2  number of held words (0, 1 or 2).

Behaviour:
- Handshake definitions:
  - Transfer in occurs on a rising edge where in_valid && in_ready.
  - Transfer out occurs on a rising edge where out_valid && out_ready.
- Storage:
  - main register: the word presented on out_data.
  - skid register: holds the second word while main is stalled.
  - Each register loads only when its enable is high; otherwise it holds.
- States: EMPTY (count=0), BUSY (count=1), FULL (count=2). State is encoded in registers; count is decoded from state.
- Reset (reset=0, asynchronous): state=EMPTY; main=0, skid=0; out_valid=0, out_data=0, count=0, in_ready=1.
- Outputs:
  - in_ready = (state != FULL) && !flush. Combinational from state and flush only; never from out_ready.
  - out_valid = (state != EMPTY).
  - out_data = main. Stable while out_valid && !out_ready.
- Transitions when flush=0:
  - EMPTY:
    - in_valid: main<=in_data, go to BUSY.
    - else stay in EMPTY.
  - BUSY:
    - in_valid && out_ready: main<=in_data, stay in BUSY (pass-through, 1 word/cycle).
    - in_valid && !out_ready: skid<=in_data, go to FULL.
    - !in_valid && out_ready: go to EMPTY.
    - else hold.
  - FULL (in_ready=0, in_valid ignored):
    - out_ready: main<=skid, go to BUSY.
    - else hold.
- Latency: a word accepted into EMPTY appears on out_data with out_valid=1 one cycle later.
- Ordering: strict FIFO. The skid word is never presented before the main word.
- Flush:
  - flush=1 on a rising edge forces state=EMPTY. Data registers are unchanged.
  - flush has priority over every other event. An in_valid in the same cycle is not accepted, because in_ready=0.
  - An out_ready in the same cycle consumes nothing new; the word is discarded with the flush.
- Reset mid-operation: held words are lost. Outputs go to reset values without waiting for a clock edge.
- Sampling: inputs are sampled only at the rising edge. Glitches between edges have no effect.

Test Plan:
1. Hold reset=0 for 2 cycles, then release; keep in_valid=0 -> out_valid=0, out_data=00, count=0, in_ready=1 throughout.
2. Stream 8'h11, 8'h22, 8'h33 on consecutive cycles with out_ready=1 -> out_data shows 11, 22, 33 on consecutive cycles, each one cycle after acceptance; count stays 1; in_ready stays 1.
3. Accept 8'hAA then 8'h55 with out_ready=0 -> count=2, in_ready=0, out_data=AA. Drive 8'hF0 while in_ready=0 -> F0 is not accepted. Raise out_ready for 2 cycles -> out_data AA then 55, count 2->1->0.
4. While in FULL (AA, 55), assert flush with in_valid=1 and in_data=8'h33 -> next cycle count=0, out_valid=0, in_ready=1; 33 never appears on out_data.
5. While in BUSY holding 8'hC3, pull reset low between clock edges -> out_valid=0, out_data=00, count=0 immediately, with no clock edge needed.
6. Random in_valid/out_ready for 1000 cycles, checked against a scoreboard queue -> output order matches input order, no word lost or duplicated, count equals queue depth every cycle.
